// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// -------------------
// Bundles the signals between the M-stage load/store responder and the
// pipeline and data memory that surround it.
//   Pipeline side : MemReadM, MemWriteM, LS_modeM, ALUResultM, WriteDataM (to unit)
//                   StallM, ReadDataM, ErrM                             (from unit)
//   Memory side   : mem_req, mem_we, mem_addr, mem_wdata, mem_be        (from unit)
//                   mem_ack, mem_rdata                                  (to unit)
// slave  : view taken by mem_access_unit
// master : view taken by the environment (pipeline + memory model)
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      MemReadM;
  logic                      MemWriteM;
  logic [2:0]                LS_modeM;
  logic [DATA_WIDTH-1:0]     ALUResultM;
  logic [DATA_WIDTH-1:0]     WriteDataM;
  logic                      StallM;
  logic [DATA_WIDTH-1:0]     ReadDataM;
  logic                      ErrM;
  logic                      mem_req;
  logic                      mem_we;
  logic [DATA_WIDTH-3:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic                      mem_ack;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  MemReadM, MemWriteM, LS_modeM, ALUResultM, WriteDataM,
    input  mem_ack, mem_rdata,
    output StallM, ReadDataM, ErrM,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output MemReadM, MemWriteM, LS_modeM, ALUResultM, WriteDataM,
    output mem_ack, mem_rdata,
    input  StallM, ReadDataM, ErrM,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Memory-stage load/store responder. Turns the M-stage request into a
// word-wide req/ack data-memory access with byte enables, stalls the pipeline
// until the access completes, and returns an aligned, sign/zero-extended load
// result in the DONE cycle.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_access_unit_if.slave (pipeline request/response + memory port)
// Parameters:
//   DATA_WIDTH : datapath width, only 32 supported
//   TIMEOUT    : max BUSY cycles waiting for mem_ack, 0 disables the watchdog
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.slave  bus
);

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                  state_r, state_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic                    to_r, to_s;
  logic [DATA_WIDTH-1:0]   rdata_q_r, rdata_q_s;

  logic                    access_s;
  logic                    fault_s;
  logic                    mode_bad_s;
  logic                    misalign_s;
  logic                    mem_req_s;
  logic                    stall_s;
  logic                    err_s;
  logic                    done_s;
  logic [DATA_WIDTH-1:0]   wdata_s;
  logic [3:0]              be_s;
  logic [DATA_WIDTH-1:0]   shifted_s;
  logic [7:0]              byte_s;
  logic [15:0]             half_s;
  logic [DATA_WIDTH-1:0]   ext_s;

  // Request decode: a fault suppresses the memory request entirely.
  always_comb begin
    access_s   = bus.MemReadM | bus.MemWriteM;
    // 011 and 11x are never legal; unsigned modes (1xx) make no sense for stores.
    mode_bad_s = (bus.LS_modeM == 3'b011) || (bus.LS_modeM[2:1] == 2'b11) ||
                 (bus.MemWriteM && bus.LS_modeM[2]);
    misalign_s = ((bus.LS_modeM[1:0] == 2'b01) && bus.ALUResultM[0]) ||
                 ((bus.LS_modeM[1:0] == 2'b10) && (bus.ALUResultM[1:0] != 2'b00));
    fault_s    = access_s &&
                 ((bus.MemReadM && bus.MemWriteM) || mode_bad_s || misalign_s);
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    wdata_s = {DATA_WIDTH{1'b0}};
    be_s    = 4'b1111;
    if (bus.MemWriteM) begin
      case (bus.LS_modeM[1:0])
        2'b00: begin
          wdata_s = {4{bus.WriteDataM[7:0]}};
          be_s    = 4'b0001 << bus.ALUResultM[1:0];
        end
        2'b01: begin
          wdata_s = {2{bus.WriteDataM[15:0]}};
          be_s    = bus.ALUResultM[1] ? 4'b1100 : 4'b0011;
        end
        2'b10: begin
          wdata_s = bus.WriteDataM;
          be_s    = 4'b1111;
        end
        default: begin
          wdata_s = {DATA_WIDTH{1'b0}};
          be_s    = 4'b0000;
        end
      endcase
    end else begin
      wdata_s = {DATA_WIDTH{1'b0}};
      be_s    = 4'b1111;
    end
  end

  // Load alignment and extension from the captured word.
  always_comb begin
    shifted_s = rdata_q_r >> {bus.ALUResultM[1:0], 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = bus.ALUResultM[1] ? rdata_q_r[31:16] : rdata_q_r[15:0];
    case (bus.LS_modeM)
      3'b000:  ext_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  ext_s = {{16{half_s[15]}}, half_s};
      3'b010:  ext_s = rdata_q_r;
      3'b100:  ext_s = {24'h000000, byte_s};
      3'b101:  ext_s = {16'h0000, half_s};
      default: ext_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // FSM next-state, watchdog counter, read capture and handshake outputs.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    to_s      = to_r;
    rdata_q_s = rdata_q_r;
    mem_req_s = 1'b0;
    stall_s   = 1'b0;
    err_s     = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CW{1'b0}};
        to_s  = 1'b0;
        if (fault_s) begin
          err_s = 1'b1;
        end else if (access_s) begin
          mem_req_s = 1'b1;
          stall_s   = 1'b1;
          if (bus.mem_ack) begin
            rdata_q_s = bus.mem_rdata;
            state_s   = ST_DONE;
          end else begin
            state_s   = ST_BUSY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        mem_req_s = 1'b1;
        stall_s   = 1'b1;
        // An ack arriving on the timeout cycle still completes normally.
        if (bus.mem_ack) begin
          rdata_q_s = bus.mem_rdata;
          cnt_s     = {CW{1'b0}};
          state_s   = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_END)) begin
          cnt_s   = {CW{1'b0}};
          to_s    = 1'b1;
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        // No request here even if a new instruction is already presented.
        cnt_s   = {CW{1'b0}};
        to_s    = 1'b0;
        done_s  = 1'b1;
        err_s   = to_r;
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = {CW{1'b0}};
        to_s    = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, watchdog, timeout flag and captured read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      to_r      <= 1'b0;
      rdata_q_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      to_r      <= to_s;
      rdata_q_r <= rdata_q_s;
    end
  end

  // Handshake outputs are gated by rst so a reset mid-access drops them at once.
  assign bus.StallM    = stall_s   & ~rst;
  assign bus.mem_req   = mem_req_s & ~rst;
  assign bus.ErrM      = err_s     & ~rst;
  assign bus.ReadDataM = (done_s && !rst && !to_r && bus.MemReadM && !bus.MemWriteM) ?
                         ext_s : {DATA_WIDTH{1'b0}};
  assign bus.mem_we    = bus.MemWriteM;
  assign bus.mem_addr  = bus.ALUResultM[DATA_WIDTH-1:2];
  assign bus.mem_wdata = wdata_s;
  assign bus.mem_be    = be_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mem_access_unit_if bus ();

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the most recent access() call.
  int          r_stalls;
  int          r_reqs;
  logic [31:0] r_rd;
  logic        r_err;
  logic        r_done_req;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;
  logic        c_we;
  logic [29:0] c_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.MemReadM   = rd;
    bus.MemWriteM  = wr;
    bus.LS_modeM   = mode;
    bus.ALUResultM = addr;
    bus.WriteDataM = wd;
  endtask

  // Present one access; memory acks ack_at cycles after the request (-1 = never).
  // Ends at the sample of the first non-stalled cycle (DONE or fault cycle).
  task automatic access(input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ack_at);
    next_cycle();
    drive(rd, wr, mode, addr, wd);
    bus.mem_rdata = rdata;
    bus.mem_ack   = (ack_at == 0);
    r_stalls = 0;
    r_reqs   = 0;
    r_rd     = 32'hXXXX_XXXX;
    r_err    = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        c_be    = bus.mem_be;
        c_wdata = bus.mem_wdata;
        c_we    = bus.mem_we;
        c_addr  = bus.mem_addr;
      end
      if (bus.mem_req) r_reqs++;
      if (!bus.StallM) begin
        r_rd       = bus.ReadDataM;
        r_err      = bus.ErrM;
        r_done_req = bus.mem_req;
        break;
      end
      r_stalls++;
      next_cycle();
      bus.mem_ack = ((c + 1) == ack_at);
    end
  endtask

  // Return the pipeline to no-access and confirm ErrM is a single-cycle pulse.
  task automatic idle(input string tag);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check(tag, {31'h0, bus.ErrM}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset state, including a legal load presented while in reset.
    @(negedge clk);
    check("rst_stall", {31'h0, bus.StallM}, 32'h0);
    check("rst_req",   {31'h0, bus.mem_req}, 32'h0);
    check("rst_err",   {31'h0, bus.ErrM}, 32'h0);
    check("rst_rdata", bus.ReadDataM, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    #1;
    check("rst_req_gated", {31'h0, bus.mem_req}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;

    // LB 0x103, ack after 2 cycles.
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2);
    check("lb_stalls", r_stalls, 32'd3);
    check("lb_reqs",   r_reqs, 32'd3);
    check("lb_rdata",  r_rd, 32'hFFFF_FF80);
    check("lb_err",    {31'h0, r_err}, 32'h0);
    check("lb_be",     {28'h0, c_be}, 32'h0000_000F);
    check("lb_addr",   {2'b00, c_addr}, 32'h0000_0040);
    check("lb_we",     {31'h0, c_we}, 32'h0);
    idle("lb_err_after");

    // LBU same word.
    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2);
    check("lbu_stalls", r_stalls, 32'd3);
    check("lbu_rdata",  r_rd, 32'h0000_0080);
    idle("lbu_err_after");

    // SH 0xBEEF to 0x202, ack same cycle.
    access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h1111_1111, 0);
    check("sh_stalls", r_stalls, 32'd1);
    check("sh_be",     {28'h0, c_be}, 32'h0000_000C);
    check("sh_wdata",  c_wdata, 32'hBEEF_BEEF);
    check("sh_we",     {31'h0, c_we}, 32'h1);
    check("sh_addr",   {2'b00, c_addr}, 32'h0000_0080);
    check("sh_rdata",  r_rd, 32'h0);
    check("sh_err",    {31'h0, r_err}, 32'h0);
    idle("sh_err_after");

    // SB 0xAB to 0x001.
    access(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0, 0);
    check("sb_be",    {28'h0, c_be}, 32'h0000_0002);
    check("sb_wdata", c_wdata, 32'hABAB_ABAB);
    idle("sb_err_after");

    // LH upper half, negative.
    access(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 1);
    check("lh_stalls", r_stalls, 32'd2);
    check("lh_rdata",  r_rd, 32'hFFFF_8001);
    idle("lh_err_after");

    // Misaligned LW and LHU: fault pulse, no request, no stall.
    access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hFFFF_FFFF, 0);
    check("lw_mis_err",    {31'h0, r_err}, 32'h1);
    check("lw_mis_reqs",   r_reqs, 32'd0);
    check("lw_mis_stalls", r_stalls, 32'd0);
    check("lw_mis_rdata",  r_rd, 32'h0);
    idle("lw_mis_err_after");
    access(1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'h0, 32'hFFFF_FFFF, 0);
    check("lhu_mis_err",    {31'h0, r_err}, 32'h1);
    check("lhu_mis_reqs",   r_reqs, 32'd0);
    check("lhu_mis_stalls", r_stalls, 32'd0);
    check("lhu_mis_rdata",  r_rd, 32'h0);
    idle("lhu_mis_err_after");

    // Illegal: read and write together.
    access(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 0);
    check("rw_err",  {31'h0, r_err}, 32'h1);
    check("rw_reqs", r_reqs, 32'd0);
    idle("rw_err_after");

    // Timeout: 1 IDLE + 4 BUSY stalled cycles, DONE with ErrM.
    access(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'h1234_5678, -1);
    check("to_stalls", r_stalls, 32'd5);
    check("to_err",    {31'h0, r_err}, 32'h1);
    check("to_rdata",  r_rd, 32'h0);
    idle("to_err_after");

    // Ack on the cycle the timeout would fire: normal completion.
    access(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'h55AA_55AA, 4);
    check("toack_stalls", r_stalls, 32'd5);
    check("toack_err",    {31'h0, r_err}, 32'h0);
    check("toack_rdata",  r_rd, 32'h55AA_55AA);
    idle("toack_err_after");

    // Reset while BUSY drops the request asynchronously.
    next_cycle();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("rb_req0", {31'h0, bus.mem_req}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("rb_busy_stall", {31'h0, bus.StallM}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rb_req_async",   {31'h0, bus.mem_req}, 32'h0);
    check("rb_stall_async", {31'h0, bus.StallM}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rb_err_after",   {31'h0, bus.ErrM}, 32'h0);
    check("rb_stall_after", {31'h0, bus.StallM}, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0);
    check("rb_lw_stalls", r_stalls, 32'd1);
    check("rb_lw_rdata",  r_rd, 32'hCAFE_F00D);
    check("rb_lw_err",    {31'h0, r_err}, 32'h0);

    // Back-to-back SW then LW, each acked one cycle after request.
    access(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 32'h0, 1);
    check("b2b_sw_stalls",   r_stalls, 32'd2);
    check("b2b_sw_reqs",     r_reqs, 32'd2);
    check("b2b_sw_done_req", {31'h0, r_done_req}, 32'h0);
    check("b2b_sw_wdata",    c_wdata, 32'h1234_5678);
    check("b2b_sw_be",       {28'h0, c_be}, 32'h0000_000F);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 1);
    check("b2b_lw_stalls",   r_stalls, 32'd2);
    check("b2b_lw_reqs",     r_reqs, 32'd2);
    check("b2b_lw_done_req", {31'h0, r_done_req}, 32'h0);
    check("b2b_lw_rdata",    r_rd, 32'hDEAD_BEEF);
    idle("b2b_err_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store responder for the pipelined RISC-V core. It consumes the EX/MEM pipeline register's M-stage request outputs (MemReadM, MemWriteM, LS_modeM, ALUResultM, WriteDataM). It drives a word-wide request/acknowledge data-memory port with byte enables. It stalls the pipeline until the access completes and returns an aligned, sign- or zero-extended ReadDataM to the writeback path.

## Interface
- DATA_WIDTH, 32: datapath width; only 32 is supported.
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemReadM  in  1  load request.
- MemWriteM  in  1  store request.
- LS_modeM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- StallM  out  1  holds IF/ID/EX/MEM stages.
- ReadDataM  out  32  extended load result.
- ErrM  out  1  one-cycle fault flag: misaligned address, illegal mode, or timeout.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  30  word address, ALUResultM[31:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- Access = MemReadM | MemWriteM.
- Faults:
  - Both MemReadM and MemWriteM high.
  - LS_modeM is 011, 11x, or (store and 1xx).
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - On a fault, no memory request is issued. ErrM = 1 and StallM = 0 for that cycle, and the FSM stays in IDLE.
- FSM states:
  - IDLE: on a legal access, mem_req = 1 and StallM = 1. If mem_ack = 1, go to DONE; otherwise go to BUSY.
  - BUSY: mem_req = 1, StallM = 1, and the timeout counter increments. On mem_ack, go to DONE. If the count reaches TIMEOUT (nonzero), go to DONE with the timeout flag set.
  - DONE: StallM = 0, mem_req = 0, and ReadDataM is valid. ErrM = 1 only if timed out. Always go to IDLE next. The pipeline advances on this edge.
- mem_we, mem_addr, mem_wdata and mem_be are combinational from the M-stage inputs. These inputs are stable while StallM = 1.
- Store lanes:
  - SB: mem_wdata = {4{wd[7:0]}}, mem_be = 0001 << addr[1:0].
  - SH: mem_wdata = {2{wd[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - SW: mem_wdata = wd, mem_be = 1111.
- Loads: mem_be = 1111 and mem_wdata = 0.
  - On the mem_ack cycle, capture mem_rdata into rdata_q.
  - In DONE, select the byte or half using addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
  - W passes the word through unchanged.
- ReadDataM = 0 outside DONE, for stores, and after a timeout.
- Timeout counter: width $clog2(TIMEOUT+1). Cleared in IDLE and DONE.

## Timing
- Reset values: state IDLE, rdata_q 0, counter 0, timeout flag 0.
- While rst = 1: StallM 0, mem_req 0, ErrM 0, ReadDataM 0.
- Reset mid-access drops mem_req immediately. No completion and no ErrM follow.
- Latency:
  - Access with ack in the same cycle: StallM high for 1 cycle, DONE in cycle 1.
  - Ack k cycles after the request: StallM high for k+1 cycles, DONE in cycle k+1.
- mem_ack outside IDLE/BUSY-with-request is ignored.
- mem_ack in the same cycle the timeout is reached: the ack wins, normal completion, ErrM 0.
- Back-to-back accesses: DONE → IDLE, so the next request issues one cycle after DONE. There is no combinational path from mem_ack to mem_req.
- A new request is never issued in DONE, even if the next instruction is already present. This prevents a duplicate issue.

## Test plan
- LB from addr 0x103, mem_rdata 0x80FF_1234 acked after 2 cycles: StallM high for 3 cycles, then ReadDataM = 0xFFFF_FF80 in DONE. Repeat with LBU: ReadDataM = 0x0000_0080.
- SH of WriteDataM 0x0000_BEEF to addr 0x202, ack in the same cycle: mem_be = 1100, mem_wdata = 0xBEEF_BEEF, mem_we = 1, mem_addr = 0x80, StallM high for exactly 1 cycle.
- LW at addr 0x101 and LHU at addr 0x3: ErrM pulses 1 for one cycle, mem_req stays 0, StallM stays 0, ReadDataM = 0.
- TIMEOUT = 4, mem_ack never asserted: BUSY lasts 4 cycles, then DONE with ErrM = 1 and ReadDataM = 0, then IDLE.
- Assert rst during BUSY: mem_req and StallM fall asynchronously. After release, state is IDLE and a fresh LW with ack completes normally.
- Back-to-back SW then LW with 1-cycle acks: exactly two mem_req episodes, no request in either DONE cycle, and the LW returns the acked word unchanged.
